// File: rtl/game_status_tx.sv
// Serial status transmitter: sends a 3-byte game status message as 8N1 frames.
// Bytes are {7'b1010010, game_active}, time_left[15:8], time_left[7:0].
module game_status_tx #(
    parameter int unsigned CLKS_PER_BIT = 10417
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        send,
    input  logic        game_active,
    input  logic [15:0] time_left,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] CntMax  = 16'(CLKS_PER_BIT - 1);
    localparam logic [6:0]  Header  = 7'b1010010;
    localparam logic [1:0]  LastByte = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic        ga_q, ga_d;
    logic [15:0] tl_q, tl_d;
    logic        tx_q, tx_d;
    logic        done_q, done_d;

    logic [7:0]  cur_byte;
    logic [2:0]  bit_nxt;
    logic        period_end;

    always_comb begin
        case (byte_q)
            2'd0:    cur_byte = {Header, ga_q};
            2'd1:    cur_byte = tl_q[15:8];
            2'd2:    cur_byte = tl_q[7:0];
            default: cur_byte = 8'h00;
        endcase
    end

    assign bit_nxt    = bit_q + 3'd1;
    assign period_end = (cnt_q == CntMax);

    // tx_d is the line level for the cycle after this edge, so tx stays a pure register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        ga_d    = ga_q;
        tl_d    = tl_q;
        tx_d    = tx_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (send) begin
                    state_d = StStart;
                    cnt_d   = 16'd0;
                    bit_d   = 3'd0;
                    byte_d  = 2'd0;
                    ga_d    = game_active;
                    tl_d    = time_left;
                    tx_d    = 1'b0;
                end
            end
            StStart: begin
                if (period_end) begin
                    cnt_d   = 16'd0;
                    state_d = StData;
                    tx_d    = cur_byte[0];
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StData: begin
                if (period_end) begin
                    cnt_d = 16'd0;
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = cur_byte[bit_nxt];
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StStop: begin
                if (period_end) begin
                    cnt_d = 16'd0;
                    if (byte_q == LastByte) begin
                        byte_d  = 2'd0;
                        state_d = StIdle;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                    end else begin
                        byte_d  = byte_q + 2'd1;
                        state_d = StStart;
                        tx_d    = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            byte_q  <= 2'd0;
            ga_q    <= 1'b0;
            tl_q    <= 16'd0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            ga_q    <= ga_d;
            tl_q    <= tl_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != StIdle);
    assign done = done_q;

endmodule

// File: tb/tb_game_status_tx.sv
// Directed bench for game_status_tx with CLKS_PER_BIT=4 (120-cycle messages).
module tb_game_status_tx;

    logic        clock;
    logic        reset;
    logic        send;
    logic        game_active;
    logic [15:0] time_left;
    logic        tx;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cycle_cnt = 0;

    game_status_tx #(.CLKS_PER_BIT(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .send        (send),
        .game_active (game_active),
        .time_left   (time_left),
        .tx          (tx),
        .busy        (busy),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

    // Expected tx waveform, index i = i-th busy cycle of the message.
    function automatic logic [119:0] frame(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2);
        logic [119:0] r;
        logic [7:0]   by;
        logic [9:0]   f;
        r = '0;
        for (int b = 0; b < 3; b++) begin
            by = (b == 0) ? b0 : (b == 1) ? b1 : b2;
            f  = {1'b1, by, 1'b0};
            for (int p = 0; p < 10; p++)
                for (int c = 0; c < 4; c++)
                    r[b*40 + p*4 + c] = f[p];
        end
        return r;
    endfunction

    // Samples the 120 message cycles; optional send pulse, held send, or time_left change.
    task automatic capture(input int send_at, input bit hold, input int tl_at,
                           input logic [15:0] tl_new, output logic [119:0] txv,
                           output logic [119:0] bv, output int nd);
        nd = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clock);
            txv[i] = tx;
            bv[i]  = busy;
            if (done) nd++;
            send = hold || (i == send_at);
            if (i == tl_at) time_left = tl_new;
        end
    endtask

    task automatic test_reset();
        logic [119:0] txv, bv;
        int nd;
        reset = 1'b1; send = 1'b1; game_active = 1'b1; time_left = 16'h012C;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx c%0d got %b want 1", i, tx); end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy c%0d got %b want 0", i, busy); end
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL reset_done c%0d got %b want 0", i, done); end
        end
        reset = 1'b0;
        capture(-1, 1'b0, -1, 16'h0, txv, bv, nd);
        checks++;
        if (txv[0] !== 1'b0 || bv[0] !== 1'b1) begin
            errors++; $display("FAIL first_accept got tx=%b busy=%b want tx=0 busy=1", txv[0], bv[0]);
        end
        checks++;
        if (txv !== frame(8'hA5, 8'h01, 8'h2C)) begin
            errors++;
            $display("FAIL basic_tx got %h want %h", txv, frame(8'hA5, 8'h01, 8'h2C));
        end
        checks++;
        if (bv !== {120{1'b1}}) begin errors++; $display("FAIL basic_busy got %h want all ones", bv); end
        checks++;
        if (nd !== 0) begin errors++; $display("FAIL basic_early_done got %0d want 0", nd); end
        @(negedge clock);
        checks++;
        if ({done, busy, tx} !== 3'b101) begin
            errors++; $display("FAIL basic_done got done,busy,tx=%b want 101", {done, busy, tx});
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b want 0", done); end
    endtask

    task automatic test_ignore_busy();
        logic [119:0] txv, bv;
        int nd, nb;
        send = 1'b1; game_active = 1'b0; time_left = 16'h5A3C;
        capture(49, 1'b0, -1, 16'h0, txv, bv, nd);
        checks++;
        if (txv !== frame(8'hA4, 8'h5A, 8'h3C)) begin
            errors++;
            $display("FAIL ignore_tx got %h want %h", txv, frame(8'hA4, 8'h5A, 8'h3C));
        end
        checks++;
        if (bv !== {120{1'b1}}) begin errors++; $display("FAIL ignore_busy got %h want all ones", bv); end
        @(negedge clock);
        checks++;
        if ({done, busy, tx} !== 3'b101) begin
            errors++; $display("FAIL ignore_done got done,busy,tx=%b want 101", {done, busy, tx});
        end
        nb = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (busy || done) nb++;
        end
        checks++;
        if (nb !== 0) begin errors++; $display("FAIL ignore_queued got %0d busy cycles want 0", nb); end
    endtask

    task automatic test_latch();
        logic [119:0] txv, bv;
        int nd;
        send = 1'b1; game_active = 1'b0; time_left = 16'h0000;
        capture(-1, 1'b0, 0, 16'hFFFF, txv, bv, nd);
        checks++;
        if (txv !== frame(8'hA4, 8'h00, 8'h00)) begin
            errors++;
            $display("FAIL latch_tx got %h want %h", txv, frame(8'hA4, 8'h00, 8'h00));
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL latch_done got %b want 1", done); end
        time_left = 16'h0000;
    endtask

    task automatic test_back_to_back();
        logic [119:0] txv, bv;
        int nd, t1, t2;
        send = 1'b1; game_active = 1'b1; time_left = 16'hBEEF;
        capture(-1, 1'b1, -1, 16'h0, txv, bv, nd);
        checks++;
        if (txv !== frame(8'hA5, 8'hBE, 8'hEF)) begin
            errors++;
            $display("FAIL b2b_tx1 got %h want %h", txv, frame(8'hA5, 8'hBE, 8'hEF));
        end
        @(negedge clock);
        t1 = cycle_cnt;
        checks++;
        if ({done, busy, tx} !== 3'b101) begin
            errors++; $display("FAIL b2b_done1 got done,busy,tx=%b want 101", {done, busy, tx});
        end
        capture(-1, 1'b1, -1, 16'h0, txv, bv, nd);
        checks++;
        if (txv[0] !== 1'b0) begin errors++; $display("FAIL b2b_restart got tx=%b want 0", txv[0]); end
        checks++;
        if (txv !== frame(8'hA5, 8'hBE, 8'hEF) || bv !== {120{1'b1}}) begin
            errors++; $display("FAIL b2b_tx2 got tx %h busy %h", txv, bv);
        end
        @(negedge clock);
        t2 = cycle_cnt;
        send = 1'b0;
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL b2b_done2 got %b want 1", done); end
        checks++;
        if (t2 - t1 !== 121) begin errors++; $display("FAIL b2b_spacing got %0d want 121", t2 - t1); end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_stop got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [119:0] txv, bv;
        int nd;
        send = 1'b1; game_active = 1'b1; time_left = 16'h1234;
        for (int i = 0; i < 36; i++) begin
            @(negedge clock);
            send = 1'b0;
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if ({done, busy, tx} !== 3'b001) begin
            errors++; $display("FAIL mid_reset got done,busy,tx=%b want 001", {done, busy, tx});
        end
        nd = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clock);
            if (done || busy || !tx) nd++;
        end
        checks++;
        if (nd !== 0) begin errors++; $display("FAIL mid_quiet got %0d active cycles want 0", nd); end
        send = 1'b1;
        capture(-1, 1'b0, -1, 16'h0, txv, bv, nd);
        checks++;
        if (txv !== frame(8'hA5, 8'h12, 8'h34) || bv !== {120{1'b1}}) begin
            errors++; $display("FAIL mid_resend got tx %h busy %h want tx %h",
                               txv, bv, frame(8'hA5, 8'h12, 8'h34));
        end
        @(negedge clock);
        checks++;
        if ({done, busy, tx} !== 3'b101) begin
            errors++; $display("FAIL mid_done got done,busy,tx=%b want 101", {done, busy, tx});
        end
    endtask

    initial begin
        reset = 1'b1;
        send = 1'b0;
        game_active = 1'b0;
        time_left = 16'h0000;
        test_reset();
        test_ignore_busy();
        test_latch();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
